// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : load_scoreboard
// Purpose  : Tracks destinations of in-flight loads and stalls decode on
//            load-use, WAW-on-pending-load or a full outstanding-load window.
//            Optional macro LOAD_SB_STATS_EN adds the stall_count statistic.
// Revision : 1.0 - initial release
// ============================================================================
module load_scoreboard #(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_rs1_used,
    input  logic             issue_rs2_used,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    input  logic             issue_is_load,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] load_count
`ifdef LOAD_SB_STATS_EN
    ,
    output logic [31:0]      stall_count
`endif
);

    localparam logic [CNT_W-1:0] c_max_loads = CNT_W'(MAX_LOADS);

    logic [31:0]      r_busy_mask;
    logic [CNT_W-1:0] r_load_count;

    logic [31:0]      w_wb_clear;
    logic [31:0]      w_eff_busy;
    logic [31:0]      w_set;
    logic [31:0]      w_busy_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_full;
    logic             w_accept;
    logic             w_inc;

    // A result written back this cycle is bypassed, so it is hidden from the hazard check.
    always_comb begin
        w_wb_clear = '0;
        if (wb_valid) begin
            w_wb_clear[wb_rd] = 1'b1;
        end
    end

    assign w_eff_busy = r_busy_mask & ~w_wb_clear;

    assign w_raw1 = issue_rs1_used && (issue_rs1 != 5'd0) && w_eff_busy[issue_rs1];
    assign w_raw2 = issue_rs2_used && (issue_rs2 != 5'd0) && w_eff_busy[issue_rs2];
    assign w_waw  = issue_rd_we    && (issue_rd  != 5'd0) && w_eff_busy[issue_rd];
    assign w_full = issue_is_load  && (r_load_count == c_max_loads) && !wb_valid;

    assign stall    = issue_valid && (w_raw1 || w_raw2 || w_waw || w_full);
    assign w_accept = issue_valid && !stall;
    assign w_inc    = w_accept && issue_is_load;

    always_comb begin
        w_set = '0;
        if (w_inc && issue_rd_we && (issue_rd != 5'd0)) begin
            w_set[issue_rd] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a same-cycle issue to the written-back register wins.
    assign w_busy_next = (r_busy_mask & ~w_wb_clear) | w_set;

    always_comb begin
        w_count_next = r_load_count;
        if (w_inc && !wb_valid) begin
            w_count_next = r_load_count + CNT_W'(1);
        end else if (!w_inc && wb_valid && (r_load_count != '0)) begin
            w_count_next = r_load_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy_mask  <= '0;
            r_load_count <= '0;
        end else begin
            r_busy_mask  <= w_busy_next;
            r_load_count <= w_count_next;
        end
    end

    assign busy_mask  = r_busy_mask;
    assign load_count = r_load_count;

`ifdef LOAD_SB_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && wb_valid && (r_load_count == '0)) begin
            $error("load_scoreboard: writeback with no outstanding load");
        end
    end
`endif

endmodule
`default_nettype wire
